// File: rtl/memory_stage_if.sv
// Port bundle of the memory stage: upstream uop, data-memory bus, downstream uop and bypass.
// master is the stage itself, slave is whatever surrounds it.
interface memory_stage_if #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
);
  logic            u_valid;
  logic            u_stall;
  logic [RIDX-1:0] in_rd;
  logic [XLEN-1:0] in_rd_val;
  logic [XLEN-1:0] in_rs2_val;
  logic            in_mem_en;
  logic            in_mem_st;
  logic [1:0]      in_mem_size;
  logic            in_mem_unsigned;
  logic            in_flags_valid;
  logic [3:0]      in_flags;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  logic            d_valid;
  logic            d_stall;
  logic [RIDX-1:0] out_rd;
  logic [XLEN-1:0] out_rd_val;
  logic            out_flags_valid;
  logic [3:0]      out_flags;
  logic            out_exc;

  logic            byp_r_valid;
  logic [RIDX-1:0] byp_r;
  logic [XLEN-1:0] byp_r_val;
  logic            byp_flags_valid;
  logic [3:0]      byp_flags;

  modport master (
    input  u_valid, in_rd, in_rd_val, in_rs2_val, in_mem_en, in_mem_st, in_mem_size,
           in_mem_unsigned, in_flags_valid, in_flags, mem_ack, mem_rdata, d_stall,
    output u_stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, d_valid, out_rd,
           out_rd_val, out_flags_valid, out_flags, out_exc, byp_r_valid, byp_r, byp_r_val,
           byp_flags_valid, byp_flags
  );

  modport slave (
    output u_valid, in_rd, in_rd_val, in_rs2_val, in_mem_en, in_mem_st, in_mem_size,
           in_mem_unsigned, in_flags_valid, in_flags, mem_ack, mem_rdata, d_stall,
    input  u_stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, d_valid, out_rd,
           out_rd_val, out_flags_valid, out_flags, out_exc, byp_r_valid, byp_r, byp_r_val,
           byp_flags_valid, byp_flags
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: ALU results pass through in one cycle, loads/stores issue one
// outstanding data-memory request and complete on mem_ack.
module memory_stage #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input logic           clk,
  input logic           rst,
  memory_stage_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, stateNext;
  logic            accept, misaligned, memGo, memAck, dv;
  logic [1:0]      off;
  logic [3:0]      beNext;
  logic [XLEN-1:0] wdataNext, shifted, loadVal;

  logic            dValid, outExc, outFv;
  logic [RIDX-1:0] outRd;
  logic [XLEN-1:0] outRdVal;
  logic [3:0]      outFlags;

  logic            memWe;
  logic [XLEN-1:0] memAddr, memWdata;
  logic [3:0]      memBe;
  logic [RIDX-1:0] latRd;
  logic [1:0]      latOff, latSize;
  logic            latUns, latSt, latFv;
  logic [3:0]      latFlags;

  assign off        = bus.in_rd_val[1:0];
  assign bus.u_stall = ~rst & ((state == BUSY) | (dValid & bus.d_stall));
  assign accept     = bus.u_valid & ~bus.u_stall;
  assign misaligned = (bus.in_mem_size == 2'd3) |
                      ((bus.in_mem_size == 2'd1) & off[0]) |
                      ((bus.in_mem_size == 2'd2) & (off != 2'd0));
  assign memGo      = accept & bus.in_mem_en & ~misaligned;
  assign memAck     = (state == BUSY) & bus.mem_ack;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (memGo) stateNext = BUSY;
      BUSY:    if (bus.mem_ack) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    beNext    = 4'hF;
    wdataNext = bus.in_rs2_val;
    case (bus.in_mem_size)
      2'd0: begin
        beNext    = 4'b0001 << off;
        wdataNext = {(XLEN/8){bus.in_rs2_val[7:0]}};
      end
      2'd1: begin
        beNext    = 4'b0011 << off;
        wdataNext = {(XLEN/16){bus.in_rs2_val[15:0]}};
      end
      default: ;
    endcase
  end

  // Request fields are captured once and stay frozen for the whole BUSY window.
  always_ff @(posedge clk) begin
    if (memGo) begin
      memWe    <= bus.in_mem_st;
      memAddr  <= {bus.in_rd_val[XLEN-1:2], 2'b00};
      memBe    <= beNext;
      memWdata <= wdataNext;
      latRd    <= bus.in_rd;
      latOff   <= off;
      latSize  <= bus.in_mem_size;
      latUns   <= bus.in_mem_unsigned;
      latSt    <= bus.in_mem_st;
      latFv    <= bus.in_flags_valid;
      latFlags <= bus.in_flags;
    end
  end

  assign shifted = bus.mem_rdata >> {latOff, 3'b000};

  always_comb begin
    loadVal = shifted;
    case (latSize)
      2'd0: loadVal = latUns ? XLEN'(shifted[7:0])
                             : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1: loadVal = latUns ? XLEN'(shifted[15:0])
                             : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // The output slot is always empty while BUSY, so an ack can load it unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      dValid <= 1'b0;
      outExc <= 1'b0;
    end else if (accept & (~bus.in_mem_en | misaligned)) begin
      dValid   <= 1'b1;
      outExc   <= bus.in_mem_en;
      outRd    <= bus.in_mem_en ? '0 : bus.in_rd;
      outRdVal <= bus.in_mem_en ? '0 : bus.in_rd_val;
      outFv    <= bus.in_flags_valid;
      outFlags <= bus.in_flags;
    end else if (memAck) begin
      dValid   <= 1'b1;
      outExc   <= 1'b0;
      outRd    <= latSt ? '0 : latRd;
      outRdVal <= latSt ? '0 : loadVal;
      outFv    <= latFv;
      outFlags <= latFlags;
    end else if (~bus.d_stall) begin
      dValid <= 1'b0;
    end
  end

  assign dv                  = dValid & ~rst;
  assign bus.d_valid         = dv;
  assign bus.out_rd          = outRd;
  assign bus.out_rd_val      = outRdVal;
  assign bus.out_flags_valid = outFv;
  assign bus.out_flags       = outFlags;
  assign bus.out_exc         = outExc & ~rst;
  assign bus.byp_r_valid     = dv & (outRd != '0);
  assign bus.byp_r           = outRd;
  assign bus.byp_r_val       = outRdVal;
  assign bus.byp_flags_valid = dv & outFv;
  assign bus.byp_flags       = outFlags;

  assign bus.mem_req   = (state == BUSY) & ~rst;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_be    = memBe;
  assign bus.mem_wdata = memWdata;
endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a transaction-level reference model
// (result queue plus one pending memory op), with a few directed scenarios up front.
module tb_memory_stage;
  localparam int XLEN = 32;
  localparam int RIDX = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_stage_if #(.XLEN(XLEN), .RIDX(RIDX)) bus();
  memory_stage #(.XLEN(XLEN), .RIDX(RIDX)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        exc;
    logic        fv;
    logic [3:0]  fl;
  } res_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] d;
    logic        en, st, uns, fv;
    logic [1:0]  sz;
    logic [3:0]  fl;
  } uop_t;

  res_t expQ[$];
  uop_t pend;
  bit   pending;
  int   nTests, nFail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] beOf(input logic [31:0] a, input logic [1:0] sz);
    int sh = int'(a % 4);
    if (sz == 0) return 4'(1 << sh);
    if (sz == 1) return 4'(3 << sh);
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdOf(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ldOf(input logic [31:0] a, input logic [1:0] sz,
                                       input logic uns, input logic [31:0] rdata);
    logic [31:0] w, mask, v;
    w    = rdata >> (8 * (a % 4));
    mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    v    = w & mask;
    if (!uns && sz != 2 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
    return v;
  endfunction

  function automatic uop_t mk(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d,
                              input logic en, input logic st, input logic [1:0] sz,
                              input logic uns);
    uop_t u;
    u.rd = rd; u.a = a; u.d = d; u.en = en; u.st = st; u.sz = sz; u.uns = uns;
    u.fv = rd[0]; u.fl = rd[3:0] ^ 4'hA;
    return u;
  endfunction

  function automatic uop_t rndUop();
    logic [31:0] a;
    a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
    return mk(5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)), a, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endfunction

  // One clock: drive at negedge, sample 1 ns later, then advance the model to the next edge.
  task automatic step(input bit r, input bit uv, input uop_t u, input bit dst,
                      input bit ack, input logic [31:0] rdata);
    bit   hv, expStall;
    res_t h, n;
    @(negedge clk);
    rst = r;
    bus.u_valid = uv;            bus.in_rd = u.rd;          bus.in_rd_val = u.a;
    bus.in_rs2_val = u.d;        bus.in_mem_en = u.en;      bus.in_mem_st = u.st;
    bus.in_mem_size = u.sz;      bus.in_mem_unsigned = u.uns;
    bus.in_flags_valid = u.fv;   bus.in_flags = u.fl;
    bus.d_stall = dst;           bus.mem_ack = ack;         bus.mem_rdata = rdata;
    #1;
    if (r) begin
      chk("rst_d_valid", 32'(bus.d_valid), 0);
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_u_stall", 32'(bus.u_stall), 0);
      chk("rst_out_exc", 32'(bus.out_exc), 0);
      expQ.delete();
      pending = 0;
      return;
    end
    hv       = expQ.size() != 0;
    expStall = pending || (hv && dst);
    chk("d_valid", 32'(bus.d_valid), 32'(hv));
    chk("u_stall", 32'(bus.u_stall), 32'(expStall));
    chk("mem_req", 32'(bus.mem_req), 32'(pending));
    if (pending) begin
      chk("mem_addr", bus.mem_addr, pend.a & ~32'h3);
      chk("mem_be", 32'(bus.mem_be), 32'(beOf(pend.a, pend.sz)));
      chk("mem_we", 32'(bus.mem_we), 32'(pend.st));
      if (pend.st) chk("mem_wdata", bus.mem_wdata, wdOf(pend.d, pend.sz));
    end
    if (hv) begin
      h = expQ[0];
      chk("out_exc", 32'(bus.out_exc), 32'(h.exc));
      chk("out_rd", 32'(bus.out_rd), 32'(h.rd));
      if (!h.exc) chk("out_rd_val", bus.out_rd_val, h.val);
      chk("out_fv", 32'(bus.out_flags_valid), 32'(h.fv));
      chk("byp_r_valid", 32'(bus.byp_r_valid), 32'(h.rd != 0));
      chk("byp_flags_valid", 32'(bus.byp_flags_valid), 32'(h.fv));
      if (h.fv) begin
        chk("out_flags", 32'(bus.out_flags), 32'(h.fl));
        chk("byp_flags", 32'(bus.byp_flags), 32'(h.fl));
      end
      if (h.rd != 0) begin
        chk("byp_r", 32'(bus.byp_r), 32'(h.rd));
        chk("byp_r_val", bus.byp_r_val, h.val);
      end
      if (!dst) void'(expQ.pop_front());
    end else begin
      chk("byp_r_valid_idle", 32'(bus.byp_r_valid), 0);
      chk("byp_flags_valid_idle", 32'(bus.byp_flags_valid), 0);
    end
    if (pending && ack) begin
      n.rd  = pend.st ? 5'd0 : pend.rd;
      n.val = pend.st ? 32'd0 : ldOf(pend.a, pend.sz, pend.uns, rdata);
      n.exc = 0; n.fv = pend.fv; n.fl = pend.fl;
      expQ.push_back(n);
      pending = 0;
    end else if (uv && !expStall) begin
      n.fv = u.fv; n.fl = u.fl; n.exc = 0; n.rd = u.rd; n.val = u.a;
      if (u.en && misal(u.a, u.sz)) begin
        n.exc = 1; n.rd = 0; n.val = 0;
        expQ.push_back(n);
      end else if (u.en) begin
        pend = u;
        pending = 1;
      end else begin
        expQ.push_back(n);
      end
    end
  endtask

  uop_t idle, ua, ub;

  initial begin
    nTests = 0; nFail = 0; pending = 0;
    idle = mk(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    bus.u_valid = 0; bus.d_stall = 0; bus.mem_ack = 0; bus.mem_rdata = '0;
    bus.in_rd = '0; bus.in_rd_val = '0; bus.in_rs2_val = '0; bus.in_mem_en = 0;
    bus.in_mem_st = 0; bus.in_mem_size = '0; bus.in_mem_unsigned = 0;
    bus.in_flags_valid = 0; bus.in_flags = '0;

    step(1, 0, idle, 0, 0, 0);
    step(1, 1, idle, 0, 1, 0);

    // ALU pass-through
    step(0, 1, mk(5'd3, 32'h1234, 32'd0, 0, 0, 0, 0), 0, 0, 0);
    step(0, 0, idle, 0, 0, 0);
    chk("alu_byp_r", 32'(bus.byp_r), 32'd3);
    chk("alu_byp_r_val", bus.byp_r_val, 32'h1234);

    // signed byte load, ack on the third request cycle
    step(0, 1, mk(5'd7, 32'h103, 32'd0, 1, 0, 2'd0, 0), 0, 0, 0);
    step(0, 0, idle, 0, 0, 0);
    chk("ldb_u_stall", 32'(bus.u_stall), 32'd1);
    step(0, 1, idle, 0, 0, 0);
    chk("ldb_u_stall2", 32'(bus.u_stall), 32'd1);
    step(0, 0, idle, 0, 1, 32'h80FF_FFFF);
    step(0, 0, idle, 0, 0, 0);
    chk("ldb_val", bus.out_rd_val, 32'hFFFF_FF80);

    // half store
    step(0, 1, mk(5'd9, 32'h202, 32'hABCD, 1, 1, 2'd1, 0), 0, 0, 0);
    step(0, 0, idle, 0, 1, $urandom);
    chk("sth_addr", bus.mem_addr, 32'h200);
    chk("sth_be", 32'(bus.mem_be), 32'hC);
    chk("sth_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    chk("sth_we", 32'(bus.mem_we), 32'd1);
    step(0, 0, idle, 0, 0, 0);
    chk("sth_rd", 32'(bus.out_rd), 32'd0);

    // misaligned word load
    step(0, 1, mk(5'd5, 32'h101, 32'd0, 1, 0, 2'd2, 0), 0, 0, 0);
    step(0, 0, idle, 0, 0, 0);
    chk("mis_exc", 32'(bus.out_exc), 32'd1);
    chk("mis_byp", 32'(bus.byp_r_valid), 32'd0);
    chk("mis_req", 32'(bus.mem_req), 32'd0);

    // back-pressure: B is offered throughout and must be taken exactly once
    ua = mk(5'd11, 32'hAAAA_0001, 32'd0, 0, 0, 0, 0);
    ub = mk(5'd12, 32'hBBBB_0002, 32'd0, 0, 0, 0, 0);
    step(0, 1, ua, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, ub, 1, 0, 0);
      chk("bp_u_stall", 32'(bus.u_stall), 32'd1);
      chk("bp_hold", bus.out_rd_val, 32'hAAAA_0001);
    end
    step(0, 1, ub, 0, 0, 0);
    step(0, 0, idle, 0, 0, 0);
    chk("bp_next", bus.out_rd_val, 32'hBBBB_0002);
    step(0, 0, idle, 0, 0, 0);
    chk("bp_nodup", 32'(bus.d_valid), 32'd0);

    // reset while a request is outstanding, then a stray ack
    step(0, 1, mk(5'd6, 32'h100, 32'd0, 1, 0, 2'd2, 0), 0, 0, 0);
    step(0, 0, idle, 0, 0, 0);
    step(1, 0, idle, 0, 0, 0);
    step(0, 0, idle, 0, 1, $urandom);
    chk("rst_req_gone", 32'(bus.mem_req), 32'd0);
    step(0, 0, idle, 0, 0, 0);
    chk("rst_stray_ack", 32'(bus.d_valid), 32'd0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), rndUop(),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom);
    for (int i = 0; i < 4; i++) step(0, 0, idle, 0, 1, $urandom);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RIDX, default 5, register-index width.
REQ-003 SHALL have ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- u_valid  in  1  upstream uop valid.
- u_stall  out  1  upstream must hold its uop.
- in_rd  in  RIDX  destination register.
- in_rd_val  in  XLEN  ALU result, or address for memory ops.
- in_rs2_val  in  XLEN  store data.
- in_mem_en  in  1  uop is a load/store.
- in_mem_st  in  1  store (1) / load (0).
- in_mem_size  in  2  0=byte, 1=half, 2=word.
- in_mem_unsigned  in  1  zero-extend load.
- in_flags_valid  in  1  flags field valid.
- in_flags  in  4  ALU flags.
- mem_req  out  1  data-memory request.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  word-aligned address.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ack  in  1  request completed; mem_rdata valid this cycle.
- mem_rdata  in  XLEN  read word.
- d_valid  out  1  output uop valid.
- d_stall  in  1  downstream hold.
- out_rd / out_rd_val / out_flags_valid / out_flags / out_exc  out  RIDX/XLEN/1/4/1  output uop.
- byp_r_valid / byp_r / byp_r_val  out  1/RIDX/XLEN  register bypass to execute stage.
- byp_flags_valid / byp_flags  out  1/4  flags bypass to execute stage.

Function
REQ-004 SHALL implement states IDLE and BUSY; BUSY means a memory request is outstanding; at most one request is outstanding.
REQ-005 SHALL drive u_stall = (state==BUSY) | (d_valid & d_stall), combinationally.
REQ-006 SHALL accept the input uop on a cycle with u_valid & !u_stall.
REQ-007 SHALL, for an accepted non-memory uop, register it to the output next cycle with d_valid=1, out_rd_val=in_rd_val, out_exc=0 (latency 1).
REQ-008 SHALL, while d_valid & d_stall, hold all out_* and byp_* values stable.
REQ-009 SHALL clear d_valid on a cycle where the output is consumed (d_valid & !d_stall) and no new result completes.
REQ-010 SHALL, for an accepted aligned memory uop, latch its fields and enter BUSY with mem_req=1 from the next cycle.
REQ-011 SHALL hold mem_req, mem_we, mem_addr, mem_be and mem_wdata constant while in BUSY until mem_ack.
REQ-012 SHALL, in the cycle mem_ack=1, deassert mem_req next cycle, return to IDLE, and present the result with d_valid=1 next cycle (minimum latency 2).
REQ-013 SHALL ignore mem_ack while in IDLE.
REQ-014 SHALL drive mem_addr = addr & ~3.
REQ-015 SHALL set mem_be as follows: byte = 1<<addr[1:0]; half = 3<<addr[1:0]; word = 4'hF.
REQ-016 SHALL replicate store data across lanes: byte on all 4 lanes, half on both halves.
REQ-017 SHALL extract the addressed byte or half from mem_rdata, then sign-extend it, or zero-extend it if in_mem_unsigned=1.
REQ-018 SHALL produce an out_rd_val of 0 for stores, and force out_rd=0 for stores.
REQ-019 SHALL treat a half access with addr[0]=1, or a word access with addr[1:0]!=0, as misaligned: no mem_req, latency 1, out_exc=1, out_rd=0.
REQ-020 SHALL treat in_mem_size=3 as misaligned.
REQ-021 SHALL drive byp_r_valid = d_valid & (out_rd!=0), with byp_r=out_rd and byp_r_val=out_rd_val.
REQ-022 SHALL drive byp_flags_valid = d_valid & out_flags_valid, with byp_flags=out_flags.
REQ-023 SHALL assert no bypass while BUSY; the execute stage's load-use stall covers that window.
REQ-024 SHALL pass in_flags_valid and in_flags through unchanged for every uop type.

Reset
REQ-025 SHALL, on rst, set state=IDLE, mem_req=0, d_valid=0, out_exc=0; other registers are don't-care.
REQ-026 SHALL, on rst while BUSY, abandon the request; mem_req is 0 the cycle after rst, and a later stray mem_ack is ignored.
REQ-027 SHALL drive all outputs to their reset values within the same cycle rst is sampled high and hold them until rst is low.

Verification
REQ-028 SHALL cover ALU pass-through: rd=3, rd_val=0x1234 -> d_valid next cycle, byp_r=3, byp_r_val=0x1234.
REQ-029 SHALL cover signed byte load: addr=0x103, size=0, ack after 3 cycles with rdata=0x80FFFFFF -> out_rd_val=0xFFFFFF80; u_stall high through BUSY.
REQ-030 SHALL cover half store: addr=0x202, rs2=0xABCD -> mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1, out_rd=0.
REQ-031 SHALL cover misaligned word load: addr=0x101 -> no mem_req, out_exc=1 next cycle, byp_r_valid=0.
REQ-032 SHALL cover back-pressure: d_stall=1 for 4 cycles with outputs held stable and u_stall=1; after release, the next uop is accepted with no loss or duplication.
REQ-033 SHALL cover reset mid-request: rst while BUSY -> mem_req=0, d_valid=0; a later mem_ack produces no output.
